fdiv_mantissa_pipe: RTL

//  Parametrised pipelined restoring divider for normalised FP mantissas (hidden bit included).

---
 rtl/fpu_pkg.sv | 12 +
 rtl/fdiv_mantissa_stage.sv | 45 ++++
 rtl/fdiv_mantissa_pipe.sv | 114 +++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU constants and helpers for the fdiv mantissa datapath.
package fpu_pkg;

   localparam int FPU_MANT_W = 24;
   localparam int FPU_QUO_W  = 26;

   // Number of pipeline stages needed to resolve quo_w bits at bps bits per stage (ceiling).
   function automatic int fdiv_nstage(input int quo_w, input int bps);
      return (quo_w + bps - 1) / bps;
   endfunction

endpackage

// File: rtl/fdiv_mantissa_stage.sv
// Combinational slice of the restoring mantissa divider: ITER iterations on {rem,quo,div}.
// A zero divisor forces every resolved quotient bit to 1 (all-ones quotient).
module fdiv_mantissa_stage
#(
   parameter int MANT_W = 24,
   parameter int QUO_W  = 26,
   parameter int ITER   = 3
)
(
   input  logic [MANT_W+1:0] rem_i,
   input  logic [QUO_W-1:0]  quo_i,
   input  logic [MANT_W-1:0] div_i,
   output logic [MANT_W+1:0] rem_o,
   output logic [QUO_W-1:0]  quo_o
);

   logic [MANT_W+1:0] rem_v;
   logic [MANT_W+1:0] diff_v;
   logic [MANT_W+1:0] div_ext_v;
   logic [QUO_W-1:0]  quo_v;
   logic              div_zero_v;

   // Unrolled restoring iterations: trial subtract, keep on non-negative, shift.
   always_comb begin
      rem_v      = rem_i;
      quo_v      = quo_i;
      div_ext_v  = {2'b00, div_i};
      div_zero_v = (div_i == {MANT_W{1'b0}});
      diff_v     = {(MANT_W+2){1'b0}};
      for (int i = 0; i < ITER; i++) begin
         diff_v = rem_v - div_ext_v;
         quo_v  = quo_v << 1;
         if (!diff_v[MANT_W+1] || div_zero_v) begin
            rem_v    = diff_v;
            quo_v[0] = 1'b1;
         end else begin
            quo_v[0] = 1'b0;
         end
         rem_v = rem_v << 1;
      end
      rem_o = rem_v;
      quo_o = quo_v;
   end

endmodule

// File: rtl/fdiv_mantissa_pipe.sv
// Pipelined restoring divider for normalised FP mantissas with valid/ready backpressure
// and a tag sideband. Optional sticky output enabled by defining FDIV_MANT_STICKY_EN.
// One input register followed by NSTAGE compute registers; a single global advance
// signal stalls the whole pipe when the output is held.
module fdiv_mantissa_pipe
   import fpu_pkg::*;
#(
   parameter int MANT_W = FPU_MANT_W,
   parameter int QUO_W  = FPU_QUO_W,
   parameter int BPS    = 3,
   parameter int TAG_W  = 8
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [MANT_W-1:0] dividend,
   input  logic [MANT_W-1:0] divisor,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [QUO_W-1:0]  quotient,
   output logic [TAG_W-1:0]  out_tag,
   output logic              sticky
);

   localparam int NSTAGE     = fdiv_nstage(QUO_W, BPS);
   localparam int FIRST_ITER = QUO_W - (NSTAGE - 1) * BPS;
   localparam int REM_W      = MANT_W + 2;

   logic                           adv_s;
   logic [REM_W-1:0]               rem_q [0:NSTAGE-1];
   logic [MANT_W-1:0]              div_q [0:NSTAGE-1];
   logic [QUO_W-1:0]               quo_q [0:NSTAGE];
   logic [TAG_W-1:0]               tag_q [0:NSTAGE];
   logic [NSTAGE:0]                val_q;
   logic [NSTAGE-1:0][REM_W-1:0]   rem_s;
   logic [NSTAGE-1:0][QUO_W-1:0]   quo_s;

   assign adv_s    = (~val_q[NSTAGE]) | out_ready;
   assign in_ready = adv_s;

   // Stage 0 absorbs the remainder bits so every later stage resolves exactly BPS bits.
   for (genvar g = 0; g < NSTAGE; g++) begin : g_stage
      localparam int ITER = (g == 0) ? FIRST_ITER : BPS;
      fdiv_mantissa_stage #(
         .MANT_W (MANT_W),
         .QUO_W  (QUO_W),
         .ITER   (ITER)
      ) u_stage (
         .rem_i  (rem_q[g]),
         .quo_i  (quo_q[g]),
         .div_i  (div_q[g]),
         .rem_o  (rem_s[g]),
         .quo_o  (quo_s[g])
      );
   end

   // Pipeline registers: load the input beat and shift every stage when the pipe advances.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NSTAGE; k++) begin
            rem_q[k] <= {REM_W{1'b0}};
            div_q[k] <= {MANT_W{1'b0}};
         end
         for (int k = 0; k <= NSTAGE; k++) begin
            quo_q[k] <= {QUO_W{1'b0}};
            tag_q[k] <= {TAG_W{1'b0}};
         end
         val_q <= {(NSTAGE+1){1'b0}};
      end else if (adv_s) begin
         rem_q[0] <= {2'b00, dividend};
         quo_q[0] <= {QUO_W{1'b0}};
         div_q[0] <= divisor;
         tag_q[0] <= in_tag;
         val_q[0] <= in_valid;
         for (int k = 1; k < NSTAGE; k++) begin
            rem_q[k] <= rem_s[k-1];
            div_q[k] <= div_q[k-1];
         end
         for (int k = 1; k <= NSTAGE; k++) begin
            quo_q[k] <= quo_s[k-1];
            tag_q[k] <= tag_q[k-1];
            val_q[k] <= val_q[k-1];
         end
      end
   end

   assign out_valid = val_q[NSTAGE];
   assign quotient  = quo_q[NSTAGE];
   assign out_tag   = tag_q[NSTAGE];

`ifdef FDIV_MANT_STICKY_EN
   logic sticky_q;

   // Sticky flag: OR of the final remainder, registered in step with the quotient.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_q <= 1'b0;
      end else if (adv_s) begin
         sticky_q <= |rem_s[NSTAGE-1];
      end
   end

   assign sticky = sticky_q;
`else
   logic unused_rem_s;

   assign unused_rem_s = ^rem_s[NSTAGE-1];
   assign sticky       = 1'b0;
`endif

endmodule
